// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream loader for the processor instruction memory
//
// Receives a 16-bit big-endian word count followed by that many big-endian
// 32-bit words over a valid/ready byte link. Each assembled word is written to
// the instruction memory at consecutive addresses starting from 0. The
// processor is held in reset until the whole image has been written.
//
// Ports:
//   i_clock          single clock, all state updates on the rising edge
//   i_reset          synchronous, active-low reset (0 = reset)
//   i_in_valid       byte available on i_in_data
//   i_in_data        stream byte
//   o_in_ready       loader accepts the byte this cycle
//   o_mem_wen        memory write enable, one-cycle pulse per word
//   o_mem_addr       word address of the write
//   o_mem_data       word to write
//   o_cpu_reset      active-high processor reset, 1 until the load completes
//   o_load_done      sticky: image loaded
//   o_load_error     sticky: header count larger than DEPTH
//   o_words_loaded   number of words written so far

module imem_loader #(
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 4096
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_in_valid,
    input  logic [7:0]            i_in_data,
    output logic                  o_in_ready,
    output logic                  o_mem_wen,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [31:0]           o_mem_data,
    output logic                  o_cpu_reset,
    output logic                  o_load_done,
    output logic                  o_load_error,
    output logic [ADDR_WIDTH:0]   o_words_loaded
);

    typedef enum logic [2:0] {
        S_LEN_HI = 3'd0,
        S_LEN_LO = 3'd1,
        S_CHECK  = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    // One extra bit so that the unsigned count > DEPTH test cannot wrap.
    localparam logic [16:0] L_DEPTH = 17'(DEPTH);

    // Registered state
    state_t                r_state;
    logic [15:0]           r_count;
    logic [23:0]           r_word;        // first three bytes of the word in progress
    logic [1:0]            r_byte_idx;
    logic [ADDR_WIDTH:0]   r_word_idx;    // also serves as the words-loaded counter
    logic                  r_mem_wen;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [31:0]           r_mem_data;
    logic                  r_cpu_reset;
    logic                  r_load_done;
    logic                  r_load_error;

    // Next-state values
    state_t                w_state_nxt;
    logic [15:0]           w_count_nxt;
    logic [23:0]           w_word_nxt;
    logic [1:0]            w_byte_idx_nxt;
    logic [ADDR_WIDTH:0]   w_word_idx_nxt;
    logic                  w_mem_wen_nxt;
    logic [ADDR_WIDTH-1:0] w_mem_addr_nxt;
    logic [31:0]           w_mem_data_nxt;
    logic                  w_cpu_reset_nxt;
    logic                  w_load_done_nxt;
    logic                  w_load_error_nxt;

    logic                  w_in_ready;
    logic                  w_accept;
    logic [ADDR_WIDTH:0]   w_word_idx_inc;

    // Ready is a pure state decode, forced low while reset is asserted so no
    // byte can be consumed by an aborted load.
    assign w_in_ready = i_reset && ((r_state == S_LEN_HI) ||
                                    (r_state == S_LEN_LO) ||
                                    (r_state == S_DATA));
    assign w_accept       = i_in_valid && w_in_ready;
    assign w_word_idx_inc = r_word_idx + {{ADDR_WIDTH{1'b0}}, 1'b1};

    always_comb begin
        w_state_nxt      = r_state;
        w_count_nxt      = r_count;
        w_word_nxt       = r_word;
        w_byte_idx_nxt   = r_byte_idx;
        w_word_idx_nxt   = r_word_idx;
        w_mem_wen_nxt    = 1'b0;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_data_nxt   = r_mem_data;
        w_cpu_reset_nxt  = r_cpu_reset;
        w_load_done_nxt  = r_load_done;
        w_load_error_nxt = r_load_error;

        case (r_state)
            S_LEN_HI: begin
                if (w_accept) begin
                    w_count_nxt = {i_in_data, r_count[7:0]};
                    w_state_nxt = S_LEN_LO;
                end
            end

            S_LEN_LO: begin
                if (w_accept) begin
                    w_count_nxt = {r_count[15:8], i_in_data};
                    w_state_nxt = S_CHECK;
                end
            end

            S_CHECK: begin
                if (r_count == 16'd0) begin
                    w_state_nxt     = S_DONE;
                    w_load_done_nxt = 1'b1;
                    w_cpu_reset_nxt = 1'b0;
                end else if ({1'b0, r_count} > L_DEPTH) begin
                    w_state_nxt      = S_ERROR;
                    w_load_error_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_DATA;
                end
            end

            S_DATA: begin
                if (w_accept) begin
                    if (r_byte_idx == 2'd3) begin
                        // The write strobe is registered here so it is high for
                        // the whole WRITE cycle that follows the fourth byte.
                        w_mem_wen_nxt  = 1'b1;
                        w_mem_addr_nxt = r_word_idx[ADDR_WIDTH-1:0];
                        w_mem_data_nxt = {r_word, i_in_data};
                        w_byte_idx_nxt = 2'd0;
                        w_state_nxt    = S_WRITE;
                    end else begin
                        w_word_nxt     = {r_word[15:0], i_in_data};
                        w_byte_idx_nxt = r_byte_idx + 2'd1;
                    end
                end
            end

            S_WRITE: begin
                w_word_idx_nxt = w_word_idx_inc;
                if (16'(w_word_idx_inc) == r_count) begin
                    w_state_nxt     = S_DONE;
                    w_load_done_nxt = 1'b1;
                    w_cpu_reset_nxt = 1'b0;
                end else begin
                    w_state_nxt = S_DATA;
                end
            end

            S_DONE:  w_state_nxt = S_DONE;
            S_ERROR: w_state_nxt = S_ERROR;
            default: w_state_nxt = S_LEN_HI;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state      <= S_LEN_HI;
            r_count      <= 16'd0;
            r_word       <= 24'd0;
            r_byte_idx   <= 2'd0;
            r_word_idx   <= '0;
            r_mem_wen    <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_data   <= 32'd0;
            r_cpu_reset  <= 1'b1;
            r_load_done  <= 1'b0;
            r_load_error <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_word       <= w_word_nxt;
            r_byte_idx   <= w_byte_idx_nxt;
            r_word_idx   <= w_word_idx_nxt;
            r_mem_wen    <= w_mem_wen_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_data   <= w_mem_data_nxt;
            r_cpu_reset  <= w_cpu_reset_nxt;
            r_load_done  <= w_load_done_nxt;
            r_load_error <= w_load_error_nxt;
        end
    end

    assign o_in_ready     = w_in_ready;
    assign o_mem_wen      = r_mem_wen;
    assign o_mem_addr     = r_mem_addr;
    assign o_mem_data     = r_mem_data;
    assign o_cpu_reset    = r_cpu_reset;
    assign o_load_done    = r_load_done;
    assign o_load_error   = r_load_error;
    assign o_words_loaded = r_word_idx;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader

module tb_imem_loader;

    localparam int AW    = 12;
    localparam int DEPTH = 4096;

    typedef logic [7:0]  byte_q_t[$];
    typedef logic [31:0] word_q_t[$];

    logic          clk = 1'b0;
    logic          resetn;
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_data;
    logic          cpu_reset;
    logic          load_done;
    logic          load_error;
    logic [AW:0]   words_loaded;

    int n_cmp = 0;
    int n_bad = 0;

    logic [AW+31:0] wq[$];   // every observed write: {addr, data}

    imem_loader #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .i_clock        (clk),
        .i_reset        (resetn),
        .i_in_valid     (in_valid),
        .i_in_data      (in_data),
        .o_in_ready     (in_ready),
        .o_mem_wen      (mem_wen),
        .o_mem_addr     (mem_addr),
        .o_mem_data     (mem_data),
        .o_cpu_reset    (cpu_reset),
        .o_load_done    (load_done),
        .o_load_error   (load_error),
        .o_words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Write monitor: a stretched pulse would be recorded twice.
    always @(negedge clk) begin
        if (mem_wen === 1'b1) wq.push_back({mem_addr, mem_data});
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic byte_q_t make_stream(input int cnt, input word_q_t w);
        byte_q_t s;
        s.push_back(8'(cnt / 256));
        s.push_back(8'(cnt % 256));
        foreach (w[i]) for (int b = 3; b >= 0; b--) s.push_back(8'(w[i] >> (8 * b)));
        return s;
    endfunction

    // Decodes a stream: word count, whether it is rejected, the words expected in memory.
    task automatic model(input byte_q_t s, output int cnt, output bit err, output word_q_t w);
        cnt = int'(s[0]) * 256 + int'(s[1]);
        err = (cnt > DEPTH);
        w = {};
        if (!err)
            for (int i = 0; i < cnt; i++)
                w.push_back({s[2+4*i], s[3+4*i], s[4+4*i], s[5+4*i]});
    endtask

    // ---------------- stimulus ----------------
    task automatic do_reset(input int cycles);
        @(negedge clk);
        resetn   = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (cycles) @(negedge clk);
        resetn = 1'b1;
    endtask

    // Presents the bytes with random idle cycles, holding each byte until taken.
    // The cycle after LEN_LO and after each fourth data byte must show ready low.
    task automatic drive(input byte_q_t s, input int gap_pct);
        int   idx   = 0;
        int   cyc   = 0;
        int   limit = 8 * s.size() + 200;
        bit   held  = 1'b0;
        bit   exp_nr = 1'b0;
        logic rdy;
        while (idx < s.size()) begin
            @(negedge clk);
            if (!held) begin
                if ($urandom_range(0, 99) < gap_pct) in_valid = 1'b0;
                else begin
                    in_valid = 1'b1;
                    in_data  = s[idx];
                end
            end
            #1 rdy = in_ready;
            if (exp_nr) begin
                n_cmp++;
                if (rdy !== 1'b0) begin
                    n_bad++;
                    $display("FAIL ready_low_check_write: in_ready=%b required 0 before byte %0d", rdy, idx);
                end
                exp_nr = 1'b0;
            end
            @(posedge clk);
            if (in_valid && rdy) begin
                idx++;
                held = 1'b0;
                if (idx == 2 || (idx > 2 && (idx - 2) % 4 == 0)) exp_nr = 1'b1;
            end else begin
                held = in_valid;
            end
            cyc++;
            if (cyc > limit) begin
                n_cmp++;
                n_bad++;
                $display("FAIL drive_timeout: accepted %0d bytes required %0d", idx, s.size());
                break;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        if (exp_nr) begin
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL ready_low_after_last: in_ready=%b required 0", in_ready);
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset(2);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({in_ready, mem_wen, mem_addr, mem_data, cpu_reset, load_done, load_error, words_loaded} !==
            {1'b0, 1'b0, 12'd0, 32'd0, 1'b1, 1'b0, 1'b0, 13'd0}) begin
            n_bad++;
            $display("FAIL reset_values: rdy=%b wen=%b addr=%h data=%h cpu_rst=%b done=%b err=%b words=%0d required 0 0 000 00000000 1 0 0 0",
                     in_ready, mem_wen, mem_addr, mem_data, cpu_reset, load_done, load_error, words_loaded);
        end
        @(negedge clk);
        resetn = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL ready_after_reset: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_stream(input string name, input byte_q_t s, input int gap_pct);
        int      cnt;
        bit      err;
        word_q_t w;
        int      base;
        model(s, cnt, err, w);
        do_reset(2);
        base = wq.size();
        drive(s, gap_pct);
        repeat (4) @(negedge clk);
        #1;
        n_cmp++;
        if ({load_done, load_error, cpu_reset, in_ready, words_loaded} !==
            {!err, err, err, 1'b0, (err ? 13'd0 : 13'(cnt))}) begin
            n_bad++;
            $display("FAIL %s status: done=%b err=%b cpu_rst=%b rdy=%b words=%0d required %b %b %b 0 %0d",
                     name, load_done, load_error, cpu_reset, in_ready, words_loaded, !err, err, err,
                     err ? 0 : cnt);
        end
        n_cmp++;
        if (wq.size() - base != w.size()) begin
            n_bad++;
            $display("FAIL %s write_count: got %0d required %0d", name, wq.size() - base, w.size());
        end else begin
            foreach (w[i]) begin
                n_cmp++;
                if (wq[base+i] !== {AW'(i), w[i]}) begin
                    n_bad++;
                    $display("FAIL %s write_%0d: got addr/data %h required %h", name, i, wq[base+i], {AW'(i), w[i]});
                end
            end
        end
    endtask

    task automatic test_zero_count();
        byte_q_t s = {8'h00, 8'h00};
        int      base;
        do_reset(2);
        base = wq.size();
        drive(s, 0);
        // Still in the CHECK cycle that follows the LEN_LO byte.
        n_cmp++;
        if ({load_done, cpu_reset} !== 2'b01) begin
            n_bad++;
            $display("FAIL zero_check_cycle: done=%b cpu_rst=%b required 0 1", load_done, cpu_reset);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({load_done, cpu_reset, load_error, in_ready, words_loaded} !== {1'b1, 1'b0, 1'b0, 1'b0, 13'd0}) begin
            n_bad++;
            $display("FAIL zero_done: done=%b cpu_rst=%b err=%b rdy=%b words=%0d required 1 0 0 0 0",
                     load_done, cpu_reset, load_error, in_ready, words_loaded);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (wq.size() != base) begin
            n_bad++;
            $display("FAIL zero_no_writes: got %0d writes required 0", wq.size() - base);
        end
    endtask

    task automatic test_abort();
        byte_q_t s = {8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        byte_q_t s2 = {8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
        int      base;
        do_reset(2);
        base = wq.size();
        drive(s, 30);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (wq.size() - base != 1 || wq[base] !== {12'd0, 32'h11223344}) begin
            n_bad++;
            $display("FAIL abort_first_word: writes=%0d last=%h required 1 00011223344",
                     wq.size() - base, wq[wq.size()-1]);
        end
        resetn = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h77;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_ready_in_reset: in_ready=%b required 0", in_ready);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({mem_wen, mem_addr, mem_data, cpu_reset, load_done, load_error, words_loaded} !==
            {1'b0, 12'd0, 32'd0, 1'b1, 1'b0, 1'b0, 13'd0}) begin
            n_bad++;
            $display("FAIL abort_reset_values: wen=%b addr=%h data=%h cpu_rst=%b done=%b err=%b words=%0d required 0 000 00000000 1 0 0 0",
                     mem_wen, mem_addr, mem_data, cpu_reset, load_done, load_error, words_loaded);
        end
        @(negedge clk);
        resetn = 1'b1;
        in_valid = 1'b0;
        base = wq.size();
        drive(s2, 0);
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (wq.size() - base != 1 || wq[base] !== {12'd0, 32'hCAFEBABE} ||
            {load_done, cpu_reset, words_loaded} !== {1'b1, 1'b0, 13'd1}) begin
            n_bad++;
            $display("FAIL abort_reload: writes=%0d first=%h done=%b cpu_rst=%b words=%0d required 1 000CAFEBABE 1 0 1",
                     wq.size() - base, wq[base], load_done, cpu_reset, words_loaded);
        end
    endtask

    // Runs after a completed two-word load without resetting.
    task automatic test_after_done();
        int base = wq.size();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'hFF;
            #1;
            n_cmp++;
            if ({in_ready, mem_wen, load_done, cpu_reset, load_error, words_loaded, mem_addr, mem_data} !==
                {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 13'd2, 12'd1, 32'h12345678}) begin
                n_bad++;
                $display("FAIL after_done_cycle_%0d: rdy=%b wen=%b done=%b cpu_rst=%b err=%b words=%0d addr=%h data=%h required 0 0 1 0 0 2 001 12345678",
                         c, in_ready, mem_wen, load_done, cpu_reset, load_error, words_loaded, mem_addr, mem_data);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (wq.size() != base) begin
            n_bad++;
            $display("FAIL after_done_writes: got %0d required 0", wq.size() - base);
        end
    endtask

    task automatic test_random(input int iters);
        for (int it = 0; it < iters; it++) begin
            word_q_t w;
            int      cnt = $urandom_range(1, 24);
            for (int i = 0; i < cnt; i++) w.push_back($urandom);
            test_stream($sformatf("random_%0d", it), make_stream(cnt, w), $urandom_range(0, 70));
        end
    endtask

    task automatic test_full_depth();
        word_q_t w;
        for (int i = 0; i < DEPTH; i++) w.push_back($urandom);
        test_stream("full_depth", make_stream(DEPTH, w), 0);
    endtask

    initial begin
        byte_q_t s_basic = {8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78};
        byte_q_t s_over  = {8'h10, 8'h01};
        resetn   = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        test_reset();
        test_stream("gaps", s_basic, 50);
        test_stream("basic", s_basic, 0);
        test_after_done();
        test_zero_count();
        test_stream("over_depth", s_over, 0);
        test_abort();
        test_random(6);
        test_full_depth();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
